nios2_mul_arbiter: RTL and testbench

- Shares one pipelined 32x32 low-word multiplier cell (unsigned, 16x16 partial products, 1-cycle registered latency, no clock enable) between two requesters, e.g. the CPU ALU path and a custom-instruction / DSP accelerator.
- Arbitrates round-robin, tracks in-flight operations by requester ID, and buffers results in a small FIFO. The cell cannot stall, so issue is credit-gated against FIFO space.
- Sits beside the multiplier cell in the CPU subsystem and drives the cell's operand inputs directly.

---
 rtl/nios2_mul_arbiter_pkg.sv | 14 +
 rtl/nios2_mul_res_fifo.sv | 52 +++++
 rtl/nios2_mul_arbiter.sv | 117 +++++++++++
 tb/tb_nios2_mul_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_mul_arbiter_pkg.sv
// Shared constants and types for the two-requester multiplier arbiter.
package nios2_mul_arbiter_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int REQ_NUM        = 2;

  typedef logic [$clog2(REQ_NUM)-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } inflight_t;

endpackage

// File: rtl/nios2_mul_res_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
module nios2_mul_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; head is gated by valid, so it still reads 0 after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  push_while_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && count == (AW+1)'(DEPTH)));

endmodule

// File: rtl/nios2_mul_arbiter.sv
// Round-robin, credit-gated sharing of one pipelined multiplier cell between two requesters.
module nios2_mul_arbiter
  import nios2_mul_arbiter_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int CELL_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic [DATA_W-1:0] cell_src1,
  output logic [DATA_W-1:0] cell_src2,
  input  logic [DATA_W-1:0] cell_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [DATA_W-1:0] res_data
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + $bits(req_id_t);

  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   inflight_count;
  logic [CNT_W:0]     credit_used;
  logic               arb_en;
  logic               can_issue;
  logic               gnt0;
  logic               gnt1;
  logic               grant_any;
  req_id_t            grant_id;
  req_id_t            rr_ptr;
  inflight_t          stage [CELL_LAT];
  inflight_t          tail;
  logic [DATA_W-1:0]  held_src1;
  logic [DATA_W-1:0]  held_src2;
  logic [ENTRY_W-1:0] head;

  // Results still in the cell count against FIFO space because the cell cannot stall.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_count};
  assign can_issue   = arb_en && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

  assign gnt0      = can_issue && req0_valid && (!req1_valid || rr_ptr == req_id_t'(0));
  assign gnt1      = can_issue && req1_valid && (!req0_valid || rr_ptr == req_id_t'(1));
  assign grant_any = gnt0 || gnt1;
  assign grant_id  = gnt1 ? req_id_t'(1) : req_id_t'(0);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // NOTE: defaults come first so every path assigns the outputs and no latch is inferred.
  always_comb begin
    cell_src1 = held_src1;
    cell_src2 = held_src2;
    if (gnt0) begin
      cell_src1 = req0_src1;
      cell_src2 = req0_src2;
    end else if (gnt1) begin
      cell_src1 = req1_src1;
      cell_src2 = req1_src2;
    end
  end

  assign tail = stage[CELL_LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_en         <= 1'b0;
      rr_ptr         <= '0;
      held_src1      <= '0;
      held_src2      <= '0;
      inflight_count <= '0;
      for (int i = 0; i < CELL_LAT; i++) stage[i] <= '0;
    end else begin
      arb_en <= 1'b1;
      if (grant_any) begin
        held_src1 <= cell_src1;
        held_src2 <= cell_src2;
      end
      // Only a contested grant hands priority to the other requester.
      if (grant_any && req0_valid && req1_valid) rr_ptr <= ~grant_id;
      stage[0] <= '{valid: grant_any, id: grant_id};
      for (int i = 1; i < CELL_LAT; i++) stage[i] <= stage[i-1];
      case ({grant_any, tail.valid})
        2'b10:   inflight_count <= inflight_count + CNT_W'(1);
        2'b01:   inflight_count <= inflight_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  nios2_mul_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_res_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tail.valid),
    .push_data ({tail.id, cell_result}),
    .pop       (res_ready),
    .valid     (res_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign res_id   = head[DATA_W];
  assign res_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_nios2_mul_arbiter.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor compares arbitration and results.
module tb_nios2_mul_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [W-1:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic [W-1:0] cell_result;
  wire          req0_ready, req1_ready, res_valid, res_id;
  wire  [W-1:0] cell_src1, cell_src2, res_data;

  always #5 clk = ~clk;

  nios2_mul_arbiter #(.DATA_W(W), .CELL_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1), .req1_src2(req1_src2),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_result(cell_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data)
  );

  // Stand-in for the shared multiplier cell: one registered stage, reset with the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cell_result <= '0;
    else          cell_result <= cell_src1 * cell_src2;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    full = (2*W)'(a) * (2*W)'(b);
    return full[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return W'($urandom);
      1:       return W'($urandom_range(0, 15));
      2:       return '1;
      default: return W'(1) << $urandom_range(0, W-1);
    endcase
  endfunction

  // Reference model: outstanding ops (issued, not yet popped) against 4 credits, plus rr preference.
  typedef struct { logic id; logic [W-1:0] data; int due; } exp_t;
  exp_t         sb[$];
  logic [W:0]   pop_log[$];
  int           gseq[$];
  int           cyc = 0;
  int           m_out = 0;
  logic         m_ptr = 1'b0;
  logic [W-1:0] m_src1 = '0, m_src2 = '0;
  int           grant_count = 0, last_grant_cyc = 0, last_pop_cyc = 0;
  logic         g0, g1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic e0, e1, ok, ev;
    if (!reset_n) begin
      sb.delete();
      m_out = 0; m_ptr = 1'b0; m_src1 = '0; m_src2 = '0;
      check("reset_res_valid", 64'(res_valid), 64'(0));
      check("reset_ready", 64'({req0_ready, req1_ready}), 64'(0));
      check("reset_res_out", 64'({res_id, res_data}), 64'(0));
      check("reset_cell_src", {cell_src1, cell_src2}, 64'(0));
    end else begin
      ok = (m_out < 4);
      e0 = 1'b0; e1 = 1'b0;
      if (ok && req0_valid && req1_valid) begin
        e0 = !m_ptr; e1 = m_ptr;
      end else if (ok) begin
        e0 = req0_valid; e1 = req1_valid;
      end
      check("req0_ready", 64'(req0_ready), 64'(e0));
      check("req1_ready", 64'(req1_ready), 64'(e1));
      if (e0 || e1) begin
        m_src1 = e1 ? req1_src1 : req0_src1;
        m_src2 = e1 ? req1_src2 : req0_src2;
        check("cell_src_grant", {cell_src1, cell_src2}, {m_src1, m_src2});
        e.id = e1; e.data = mul_ref(m_src1, m_src2); e.due = cyc + 2;
        sb.push_back(e);
        m_out++; grant_count++; last_grant_cyc = cyc;
        gseq.push_back(int'(e1));
        if (req0_valid && req1_valid) m_ptr = !e1;
      end else begin
        check("cell_src_hold", {cell_src1, cell_src2}, {m_src1, m_src2});
      end
      ev = (sb.size() > 0) && (sb[0].due <= cyc);
      check("res_valid", 64'(res_valid), 64'(ev));
      if (ev) begin
        check("res_id", 64'(res_id), 64'(sb[0].id));
        check("res_data", 64'(res_data), 64'(sb[0].data));
        if (res_ready) begin
          pop_log.push_back({res_id, res_data});
          void'(sb.pop_front());
          m_out--; last_pop_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Advance n cycles, giving each granted requester fresh operands (valid unchanged).
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); g0 = req0_ready; g1 = req1_ready;
      @(posedge clk); #1;
      if (g0) begin req0_src1 = rnd_op(); req0_src2 = rnd_op(); end
      if (g1) begin req1_src1 = rnd_op(); req1_src2 = rnd_op(); end
    end
  endtask

  task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    logic got;
    got = 1'b0;
    if (r == 0) begin req0_valid = 1'b1; req0_src1 = a; req0_src2 = b; end
    else        begin req1_valid = 1'b1; req1_src1 = a; req1_src2 = b; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = (r == 0) ? req0_ready : req1_ready;
    end
    check("grant_seen", 64'(got), 64'(1));
    @(posedge clk); #1;
    if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
    tick(); tick();
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (2) tick();

    // Single op: result at grant+2.
    res_ready = 1'b1;
    send(0, 32'd3, 32'd5);
    @(negedge clk); check("single_not_early", 64'(res_valid), 64'(0));
    @(negedge clk); check("single_valid", 64'(res_valid), 64'(1));
    check("single_data", 64'(res_data), 64'(15));
    check("single_id", 64'(res_id), 64'(0));
    tick();
    drain();

    // Wrap-around products from requester 1.
    pop_log.delete();
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(1, 32'h0001_0000, 32'h0001_0000);
    drain();
    check("wrap_count", 64'(pop_log.size()), 64'(2));
    if (pop_log.size() == 2) begin
      check("wrap_first", 64'(pop_log[0]), {31'd0, 1'b1, 32'h0000_0001});
      check("wrap_second", 64'(pop_log[1]), {31'd0, 1'b1, 32'h0000_0000});
    end

    // Contention: both valid for 6 cycles.
    gseq.delete();
    req0_valid = 1'b1; req0_src1 = 32'd11; req0_src2 = 32'd13;
    req1_valid = 1'b1; req1_src1 = 32'd17; req1_src2 = 32'd19;
    run_cycles(6);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("contend_grants", 64'(gseq.size()), 64'(6));
    for (int k = 0; k < 6 && k < gseq.size(); k++)
      check("contend_order", 64'(gseq[k]), 64'(k % 2));
    drain();

    // Backpressure: exactly four credits, then one more after a single pop.
    res_ready = 1'b0; grant_count = 0;
    req0_valid = 1'b1; req0_src1 = rnd_op(); req0_src2 = rnd_op();
    run_cycles(10);
    check("bp_grants", 64'(grant_count), 64'(4));
    @(negedge clk); check("bp_ready_low", 64'(req0_ready), 64'(0));
    @(posedge clk); #1;
    res_ready = 1'b1;
    run_cycles(1);
    res_ready = 1'b0;
    run_cycles(4);
    check("bp_one_more", 64'(grant_count), 64'(5));
    check("bp_grant_after_pop", 64'(last_grant_cyc - last_pop_cyc), 64'(1));
    req0_valid = 1'b0;
    drain();

    // Reset with two results buffered and one in flight.
    res_ready = 1'b0; grant_count = 0;
    req0_valid = 1'b1; req0_src1 = rnd_op(); req0_src2 = rnd_op();
    for (int i = 0; i < 20 && grant_count < 3; i++) run_cycles(1);
    req0_valid = 1'b0;
    #2 check("mid_buffered", 64'(res_valid), 64'(1));
    reset_n = 1'b0;
    #1 check("mid_reset_clears", 64'(res_valid), 64'(0));
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (2) tick();
    res_ready = 1'b1;
    pop_log.delete();
    repeat (5) tick();
    check("no_stale", 64'(pop_log.size()), 64'(0));
    send(0, 32'd7, 32'd9);
    drain();
    check("post_reset_count", 64'(pop_log.size()), 64'(1));
    if (pop_log.size() == 1) check("post_reset_data", 64'(pop_log[0]), 64'(63));

    // Idle: operands hold the last issue.
    repeat (10) tick();
    check("idle_src", {cell_src1, cell_src2}, {32'd7, 32'd9});
    check("idle_res_valid", 64'(res_valid), 64'(0));

    // Randomized traffic with protocol-correct requesters.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk); g0 = req0_ready; g1 = req1_ready;
      @(posedge clk); #1;
      if (g0 || !req0_valid || $urandom_range(0, 19) == 0) begin
        req0_valid = ($urandom_range(0, 9) < 6); req0_src1 = rnd_op(); req0_src2 = rnd_op();
      end
      if (g1 || !req1_valid || $urandom_range(0, 19) == 0) begin
        req1_valid = ($urandom_range(0, 9) < 6); req1_src1 = rnd_op(); req1_src2 = rnd_op();
      end
      res_ready = ($urandom_range(0, 9) < 7);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

endmodule
